// File: rtl/lsu_mem_unit.sv
// Load/store unit: one op at a time, lane-steered bus request, sign/zero-extended load result.
// Latency: accept->out_valid 3 cycles best case (1 for misaligned); result held until out_ready.
module lsu_mem_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_err,
  output logic [1:0]        out_cause,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [1:0]        req_size,
  output logic              req_wen,
  output logic [31:0]       req_wdata,
  output logic [3:0]        req_wmask,
  input  logic              resp_valid,
  input  logic [31:0]       resp_rdata,
  input  logic              resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_MIS  = 2'b01;
  localparam logic [1:0] C_BUS  = 2'b10;
  localparam logic [1:0] C_TMO  = 2'b11;

  state_t              r_state;
  state_t              w_next;
  logic                r_store;
  logic [2:0]          r_funct3;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_out_data;
  logic                r_out_err;
  logic [1:0]          r_out_cause;

  logic [1:0]          w_in_size;
  logic                w_in_mis;
  logic [1:0]          w_size;
  logic [1:0]          w_off;
  logic [31:0]         w_wdata;
  logic [3:0]          w_wmask;
  logic [31:0]         w_shift;
  logic [31:0]         w_load;
  logic                w_timeout;

  // Illegal funct3 encodings fall into the word bucket.
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_of = 2'b00;
      2'b01:   size_of = 2'b01;
      default: size_of = 2'b10;
    endcase
  endfunction

  assign w_in_size = size_of(in_funct3);
  assign w_in_mis  = ((w_in_size == 2'b01) && in_addr[0]) ||
                     ((w_in_size == 2'b10) && (in_addr[1:0] != 2'b00));
  assign w_size    = size_of(r_funct3);
  assign w_off     = r_addr[1:0];
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_wdata = r_wdata;
    w_wmask = 4'b1111;
    case (w_size)
      2'b00: begin
        w_wdata = {4{r_wdata[7:0]}};
        w_wmask = 4'b0001 << w_off;
      end
      2'b01: begin
        w_wdata = {2{r_wdata[15:0]}};
        w_wmask = 4'b0011 << w_off;
      end
      default: begin
        w_wdata = r_wdata;
        w_wmask = 4'b1111;
      end
    endcase
  end

  assign w_shift = resp_rdata >> {w_off, 3'b000};

  always_comb begin
    w_load = w_shift;
    case (w_size)
      2'b00:   w_load = r_funct3[2] ? {24'd0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load = r_funct3[2] ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = w_in_mis ? S_DONE : S_REQ;
      S_REQ:  if (req_ready) w_next = S_WAIT;
      S_WAIT: if (resp_valid || w_timeout) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_store     <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_cnt       <= '0;
      r_out_data  <= 32'd0;
      r_out_err   <= 1'b0;
      r_out_cause <= C_NONE;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_store     <= in_store;
            r_funct3    <= in_funct3;
            r_addr      <= in_addr;
            r_wdata     <= in_wdata;
            r_out_data  <= 32'd0;
            r_out_err   <= w_in_mis;
            r_out_cause <= w_in_mis ? C_MIS : C_NONE;
          end
        end
        S_REQ: begin
          if (req_ready) r_cnt <= '0;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A response in the timeout cycle still counts as a normal completion.
          if (resp_valid) begin
            r_out_data  <= (resp_err || r_store) ? 32'd0 : w_load;
            r_out_err   <= resp_err;
            r_out_cause <= resp_err ? C_BUS : C_NONE;
          end else if (w_timeout) begin
            r_out_data  <= 32'd0;
            r_out_err   <= 1'b1;
            r_out_cause <= C_TMO;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign out_cause = r_out_cause;
  assign req_valid = (r_state == S_REQ);
  assign req_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign req_size  = w_size;
  assign req_wen   = r_store;
  assign req_wdata = w_wdata;
  assign req_wmask = r_store ? w_wmask : 4'b0000;

endmodule
